// File: rtl/riscv_pkg.sv
// Shared types for the data-memory arbiter: ownership state and a memory request bundle.
// Combinational types only; no latency or flow-control implications.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic {
        CPU_OWN = 1'b0,
        DMA_OWN = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with clear and terminal flag; count updates one cycle after i_inc/i_clr.
// No backpressure: i_inc at the limit holds the count; clear-with-increment restarts at 1.
module arb_sat_counter #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_term
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_cnt_nxt;

    assign o_term = (r_cnt == W'(LIMIT));

    // Clear wins over the stored value, so clr+inc starts a fresh run at one.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_clr) begin
            w_cnt_nxt = i_inc ? W'(1) : '0;
        end else if (i_inc && !o_term) begin
            w_cnt_nxt = r_cnt + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates single-port data memory between CPU M-stage and DMA; grants are same-cycle (zero latency).
// CPU is held via cpu_stall, DMA via dma_gnt=0; DMA force-granted after STARVE_LIMIT, yields after BURST_MAX.
module dmem_arbiter
    import riscv_pkg::*;
#(
    parameter int XLEN         = riscv_pkg::XLEN,
    parameter int BURST_MAX    = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cpu_req,
    input  logic            cpu_we,
    input  logic [XLEN-1:0] cpu_addr,
    input  logic [XLEN-1:0] cpu_wdata,
    output logic [XLEN-1:0] cpu_rdata,
    output logic            cpu_stall,
    input  logic            dma_req,
    input  logic            dma_we,
    input  logic [XLEN-1:0] dma_addr,
    input  logic [XLEN-1:0] dma_wdata,
    output logic [XLEN-1:0] dma_rdata,
    output logic            dma_gnt,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    arb_state_e r_state;
    arb_state_e w_state_nxt;

    logic     w_cpu_gnt;
    logic     w_dma_gnt;
    logic     w_wait_clr;
    logic     w_wait_inc;
    logic     w_wait_term;
    logic     w_beat_clr;
    logic     w_beat_inc;
    logic     w_beat_term;
    mem_req_t w_cpu_mreq;
    mem_req_t w_dma_mreq;
    mem_req_t w_mem_mreq;

    arb_sat_counter #(.LIMIT(STARVE_LIMIT)) u_wait_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_wait_clr),
        .i_inc  (w_wait_inc),
        .o_term (w_wait_term)
    );

    arb_sat_counter #(.LIMIT(BURST_MAX)) u_beat_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_beat_clr),
        .i_inc  (w_beat_inc),
        .o_term (w_beat_term)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= CPU_OWN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cpu_gnt   = 1'b0;
        w_dma_gnt   = 1'b0;
        w_wait_clr  = 1'b0;
        w_wait_inc  = 1'b0;
        w_beat_clr  = 1'b0;
        w_beat_inc  = 1'b0;
        case (r_state)
            CPU_OWN: begin
                w_beat_clr = 1'b1;
                if (dma_req && (!cpu_req || w_wait_term)) begin
                    w_dma_gnt   = 1'b1;
                    w_beat_inc  = 1'b1;
                    w_wait_clr  = 1'b1;
                    w_state_nxt = DMA_OWN;
                end else if (cpu_req && dma_req) begin
                    w_cpu_gnt  = 1'b1;
                    w_wait_inc = 1'b1;
                end else begin
                    // Idle or uncontended CPU access breaks any contention run.
                    w_cpu_gnt  = cpu_req;
                    w_wait_clr = 1'b1;
                end
            end
            DMA_OWN: begin
                w_wait_clr = 1'b1;
                if (dma_req && !w_beat_term) begin
                    w_dma_gnt  = 1'b1;
                    w_beat_inc = 1'b1;
                end else begin
                    // Release or forced yield: CPU takes this very cycle.
                    w_cpu_gnt   = cpu_req;
                    w_beat_clr  = 1'b1;
                    w_state_nxt = CPU_OWN;
                end
            end
            default: w_state_nxt = CPU_OWN;
        endcase
        // Grants are gated by reset so an aborted burst cannot leave a partial write.
        if (!rst) begin
            w_cpu_gnt = 1'b0;
            w_dma_gnt = 1'b0;
        end
    end

    assign w_cpu_mreq = {cpu_we, cpu_addr, cpu_wdata};
    assign w_dma_mreq = {dma_we, dma_addr, dma_wdata};
    assign w_mem_mreq = w_dma_gnt ? w_dma_mreq : w_cpu_mreq;

    assign mem_we    = w_mem_mreq.we & (w_cpu_gnt | w_dma_gnt);
    assign mem_addr  = w_mem_mreq.addr;
    assign mem_wdata = w_mem_mreq.wdata;

    assign dma_gnt   = w_dma_gnt;
    assign cpu_stall = rst & cpu_req & ~w_cpu_gnt;
    assign cpu_rdata = mem_rdata;
    assign dma_rdata = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port memory behind it.
module tb_dmem_arbiter;
    import riscv_pkg::*;

    logic        clk;
    logic        rst;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        cpu_stall, dma_gnt, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] mem [0:255];

    int n_cmp = 0;
    int n_err = 0;

    dmem_arbiter #(.XLEN(32), .BURST_MAX(8), .STARVE_LIMIT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .dma_req   (dma_req),
        .dma_we    (dma_we),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_rdata (dma_rdata),
        .dma_gnt   (dma_gnt),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hA5A5_0010;
        dma_req = 1; dma_we = 1; dma_addr = 32'h200; dma_wdata = 32'h1111_2222;
        step(); step();
        #2;
        n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        n_cmp++; if (dma_gnt !== 1'b0) begin n_err++; $display("FAIL reset_dma_gnt: got %b want 0", dma_gnt); end
        n_cmp++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL reset_cpu_stall: got %b want 0", cpu_stall); end
        step();
        rst = 1;
        #2;
        n_cmp++; if (mem_we !== 1'b1) begin n_err++; $display("FAIL release_mem_we: got %b want 1", mem_we); end
        n_cmp++; if (mem_addr !== 32'h10) begin n_err++; $display("FAIL release_mem_addr: got %h want 00000010", mem_addr); end
        n_cmp++; if (mem_wdata !== 32'hA5A5_0010) begin n_err++; $display("FAIL release_mem_wdata: got %h want a5a50010", mem_wdata); end
        n_cmp++; if (dma_gnt !== 1'b0) begin n_err++; $display("FAIL release_dma_gnt: got %b want 0", dma_gnt); end
        step();
        n_cmp++; if (mem[4] !== 32'hA5A5_0010) begin n_err++; $display("FAIL release_mem_word: got %h want a5a50010", mem[4]); end
        idle_inputs();
        step();
    endtask

    task automatic test_cpu_only();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'hDEAD_BEEF;
        #2;
        n_cmp++; if (mem_we !== 1'b1) begin n_err++; $display("FAIL cpu_sw_mem_we: got %b want 1", mem_we); end
        n_cmp++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL cpu_sw_stall: got %b want 0", cpu_stall); end
        step();
        cpu_we = 0; cpu_wdata = 0;
        #2;
        n_cmp++; if (cpu_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL cpu_lw_rdata: got %h want deadbeef", cpu_rdata); end
        n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL cpu_lw_mem_we: got %b want 0", mem_we); end
        n_cmp++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL cpu_lw_stall: got %b want 0", cpu_stall); end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_dma_burst();
        logic [0:10] exp_gnt;
        int beat;
        exp_gnt = 11'b11111111011;
        beat = 0;
        dma_req = 1; dma_we = 1;
        for (int i = 0; i < 11; i++) begin
            dma_addr  = 32'h100 + 32'(beat * 4);
            dma_wdata = 32'h5000_0000 + 32'(beat);
            #2;
            n_cmp++;
            if (dma_gnt !== exp_gnt[i]) begin
                n_err++; $display("FAIL burst_gnt cycle %0d: got %b want %b", i + 1, dma_gnt, exp_gnt[i]);
            end
            if (dma_gnt === 1'b1) beat++;
            step();
        end
        idle_inputs();
        step();
        for (int k = 0; k < 10; k++) begin
            n_cmp++;
            if (mem[64 + k] !== 32'h5000_0000 + 32'(k)) begin
                n_err++; $display("FAIL burst_word %0d: got %h want %h", k, mem[64 + k], 32'h5000_0000 + 32'(k));
            end
        end
    endtask

    task automatic test_starvation();
        logic [0:13] exp_d;
        exp_d = 14'b00001111111100;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20;
        dma_req = 1; dma_we = 0; dma_addr = 32'h104;
        for (int i = 0; i < 14; i++) begin
            #2;
            n_cmp++;
            if (dma_gnt !== exp_d[i]) begin
                n_err++; $display("FAIL starve_gnt cycle %0d: got %b want %b", i + 1, dma_gnt, exp_d[i]);
            end
            n_cmp++;
            if (cpu_stall !== exp_d[i]) begin
                n_err++; $display("FAIL starve_stall cycle %0d: got %b want %b", i + 1, cpu_stall, exp_d[i]);
            end
            n_cmp++;
            if (mem_addr !== (exp_d[i] ? 32'h104 : 32'h20)) begin
                n_err++; $display("FAIL starve_addr cycle %0d: got %h want %h", i + 1, mem_addr, exp_d[i] ? 32'h104 : 32'h20);
            end
            step();
        end
        idle_inputs();
        step();
    endtask

    task automatic test_early_release();
        dma_req = 1; dma_we = 0; dma_addr = 32'h108;
        for (int i = 0; i < 3; i++) begin
            #2;
            n_cmp++;
            if (dma_gnt !== 1'b1) begin n_err++; $display("FAIL early_beat %0d: got %b want 1", i + 1, dma_gnt); end
            step();
        end
        dma_req = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
        #2;
        n_cmp++; if (dma_gnt !== 1'b0) begin n_err++; $display("FAIL early_dma_gnt: got %b want 0", dma_gnt); end
        n_cmp++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL early_stall: got %b want 0", cpu_stall); end
        n_cmp++; if (cpu_rdata !== 32'h5000_0000) begin n_err++; $display("FAIL early_rdata: got %h want 50000000", cpu_rdata); end
        step();
        n_cmp++; if (dut.u_beat_cnt.r_cnt !== 4'd0) begin n_err++; $display("FAIL early_beat_cnt: got %0d want 0", dut.u_beat_cnt.r_cnt); end
        n_cmp++; if (dut.r_state !== CPU_OWN) begin n_err++; $display("FAIL early_state: got %0d want 0", dut.r_state); end
        idle_inputs();
        step();
    endtask

    task automatic test_mid_burst_reset();
        dma_req = 1; dma_we = 1;
        for (int i = 0; i < 3; i++) begin
            dma_addr = 32'h180 + 32'(i * 4); dma_wdata = 32'h7700_0000 + 32'(i);
            #2;
            n_cmp++;
            if (dma_gnt !== 1'b1) begin n_err++; $display("FAIL midrst_beat %0d: got %b want 1", i + 1, dma_gnt); end
            step();
        end
        dma_addr = 32'h18C; dma_wdata = 32'h7700_0003;
        #2;
        n_cmp++; if (dma_gnt !== 1'b1) begin n_err++; $display("FAIL midrst_beat 4: got %b want 1", dma_gnt); end
        rst = 0;
        #1;
        n_cmp++; if (dma_gnt !== 1'b0) begin n_err++; $display("FAIL midrst_dma_gnt: got %b want 0", dma_gnt); end
        n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL midrst_mem_we: got %b want 0", mem_we); end
        step();
        n_cmp++; if (mem[99] !== 32'h0) begin n_err++; $display("FAIL midrst_no_write: got %h want 00000000", mem[99]); end
        n_cmp++; if (mem[98] !== 32'h7700_0002) begin n_err++; $display("FAIL midrst_beat3_word: got %h want 77000002", mem[98]); end
        rst = 1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20;
        #2;
        n_cmp++; if (dut.r_state !== CPU_OWN) begin n_err++; $display("FAIL midrst_state: got %0d want 0", dut.r_state); end
        n_cmp++; if (dma_gnt !== 1'b0) begin n_err++; $display("FAIL midrst_release_dma: got %b want 0", dma_gnt); end
        n_cmp++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL midrst_release_stall: got %b want 0", cpu_stall); end
        n_cmp++; if (cpu_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL midrst_release_rdata: got %h want deadbeef", cpu_rdata); end
        step();
        idle_inputs();
        step();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        rst = 0;
        idle_inputs();
        #1;
        test_reset();
        test_cpu_only();
        test_dma_burst();
        test_starvation();
        test_early_release();
        test_mid_burst_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
